lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory-stage load/store unit of the 3-stage RISC-V core. It sits downstream of the execute-to-memory pipeline register, consuming the held address, store data, opcode and func3. It runs the data-bus request/grant/response handshake, generates byte enables and store-data lanes, and aligns and sign-extends load data for writeback. It drives the `stall` that freezes the upstream pipeline registers while an access is outstanding.

## Interface
- DW, 32, data/address width; only 32 supported
- BEW, DW/8, byte-enable width
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-high
- alu_out_m  in  DW  effective address from the memory-stage register
- write_data_m  in  DW  store source (rs2) value
- opcode_m  in  7  load 7'b0000011, store 7'b0100011; any other value means no access
- func3_m  in  3  access size/sign
- stall_o  out  1  freezes upstream pipeline registers
- load_data_o  out  DW  aligned, extended load result
- load_valid_o  out  1  load_data_o valid this cycle
- misalign_o  out  1  misaligned-access pulse
- dbus_req_o  out  1  request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  DW  word-aligned address ({addr[DW-1:2],2'b00})
- dbus_be_o  out  BEW  byte enables
- dbus_wdata_o  out  DW  lane-replicated store data
- dbus_gnt_i  in  1  request accepted this cycle
- dbus_rvalid_i  in  1  response (read data or write ack)
- dbus_rdata_i  in  DW  read data

## Operation
- access = opcode_m is load or store, and (when trapping is compiled in) not misaligned.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if access, assert dbus_req_o. On gnt go to RESP, otherwise go to REQ. Capture is_load, func3 and addr[1:0] into registers.
  - REQ: hold dbus_req_o. On gnt go to RESP.
  - RESP: req low. On rvalid go to IDLE.
- stall_o = access AND NOT (state==RESP AND dbus_rvalid_i). Combinational. Request fields are driven from the *_m inputs, which are held stable by the stall.
- Store lanes, using off = addr[1:0]:
  - SB (000): wdata = byte x4, be = 4'b0001<<off
  - SH (001): wdata = half x2, be = 4'b0011<<off
  - SW (010) and any other func3: be = 4'b1111
  - Loads drive be = 4'b1111.
- Load extract, using the captured off and func3:
  - LB 000, LH 001: sign-extend
  - LBU 100, LHU 101: zero-extend
  - LW 010 and any other func3: full word
- load_valid_o = state==RESP AND rvalid AND captured is_load. load_data_o is 0 whenever load_valid_o is low.
- Reset values:
  - state = IDLE; all captured registers are 0.
  - stall_o, dbus_req_o and misalign_o are 0, unless a load/store opcode is presented during reset, in which case stall_o follows the combinational rule.
  - load_valid_o = 0, load_data_o = 0.

## Timing
- Best case: req and gnt in cycle 0, rvalid in cycle 1. stall_o is high in cycle 0 and low in cycle 1. The pipeline advances at the end of cycle 1.
- Each cycle of gnt delay or rvalid delay adds one stall cycle.
- gnt or rvalid arriving in an unexpected state is ignored.
- Back-to-back accesses: the next instruction enters in the cycle after rvalid. IDLE issues its request immediately, with no bubble.
- rvalid in the same cycle as gnt is illegal; the bus guarantees it never happens.
- Reset mid-access (REQ or RESP): state returns to IDLE immediately and req drops asynchronously. A late rvalid after reset is ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - No bus request is issued and stall_o stays low.
  - misalign_o is high for every cycle the access is presented.
  - load_valid_o stays low.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign_o is tied 0.
  - Halfword accesses use offset {addr[1],1'b0}; word accesses use offset 0. The low address bits are silently aligned down.

## Structure
- lsu_pkg holds:
  - opcode constants OPC_LOAD and OPC_STORE
  - func3 enum F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_e {IDLE, REQ, RESP}
- One sub-module, lsu_align, is purely combinational: store lane/BE generation and load extract/extension.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle, rvalid next cycle -> be 4'b1111, we=1, stall_o high for exactly 1 cycle.
- SB addr 0x103, data 0x000000A5 -> wdata 0xA5A5A5A5, be 4'b1000.
- LB addr 0x102, rdata 0x12F40000 -> load_data_o 0xFFFFFFF4. LBU at the same address -> 0x000000F4.
- LH addr 0x200, gnt delayed 2 cycles, rvalid 3 cycles after gnt -> stall_o high for 5 cycles, req high for 3 cycles, load_valid_o pulses once.
- rst_i asserted in RESP, then rvalid after release -> no load_valid_o, state IDLE, dbus_req_o 0.
- LW addr 0x102 -> with the macro: misalign_o=1, no req. Without it: dbus_addr_o 0x100 and the full word is returned.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared constants and types for the memory-stage load/store unit.
//   LSU_DW     : datapath width (only 32 is supported)
//   OPC_LOAD   : RV32 load major opcode
//   OPC_STORE  : RV32 store major opcode
//   func3_e    : access size / sign encodings
//   lsu_state_e: bus handshake FSM states
//   eff_off()  : byte offset actually used for lane selection
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int LSU_DW = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } func3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Halfwords snap to a 16-bit boundary and words to offset 0, so an
    // unaligned address is quietly aligned down when trapping is not built in.
    function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] a);
        logic [1:0] o;
        case (f3)
            F3_B, F3_BU: o = a;
            F3_H, F3_HU: o = {a[1], 1'b0};
            default:     o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering for the LSU.
//   Store side: byte enables and lane-replicated write data from func3/offset.
//   Load side : byte/half/word extract with sign or zero extension.
// Ports:
//   is_load   in   access is a load (forces all byte enables)
//   st_func3  in   store size
//   st_off    in   effective byte offset of the store
//   st_data   in   rs2 value
//   st_be     out  byte enables
//   st_wdata  out  replicated store data
//   ld_func3  in   captured load size/sign
//   ld_off    in   captured effective byte offset
//   ld_rdata  in   raw bus read data
//   ld_data   out  aligned, extended load value
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic              is_load,
    input  logic [2:0]        st_func3,
    input  logic [1:0]        st_off,
    input  logic [LSU_DW-1:0] st_data,
    output logic [3:0]        st_be,
    output logic [LSU_DW-1:0] st_wdata,
    input  logic [2:0]        ld_func3,
    input  logic [1:0]        ld_off,
    input  logic [LSU_DW-1:0] ld_rdata,
    output logic [LSU_DW-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_func3)
            F3_B: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_be    = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
        if (is_load) begin
            st_be = 4'b1111;
        end
    end

    assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_func3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Memory-stage load/store unit: data-bus req/gnt/rvalid handshake, store lane
// generation, load alignment/extension and the upstream pipeline stall.
// Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
// accesses are suppressed and flagged on misalign_o; otherwise the low address
// bits are aligned down and misalign_o is tied low.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   alu_out_m               effective address
//   write_data_m            store source data
//   opcode_m, func3_m       instruction class and size/sign
//   stall_o                 freeze upstream registers
//   load_data_o/_valid_o    writeback load result
//   misalign_o              misaligned-access flag
//   dbus_*                  data bus request/response
//
// state | meaning
// IDLE  | no access outstanding; a new access requests immediately
// REQ   | request held, waiting for grant
// RESP  | granted, waiting for read data / write ack
// -----------------------------------------------------------------------------
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int DW  = 32,
    parameter int BEW = DW / 8
)
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [DW-1:0]  alu_out_m,
    input  logic [DW-1:0]  write_data_m,
    input  logic [6:0]     opcode_m,
    input  logic [2:0]     func3_m,
    output logic           stall_o,
    output logic [DW-1:0]  load_data_o,
    output logic           load_valid_o,
    output logic           misalign_o,
    output logic           dbus_req_o,
    output logic           dbus_we_o,
    output logic [DW-1:0]  dbus_addr_o,
    output logic [BEW-1:0] dbus_be_o,
    output logic [DW-1:0]  dbus_wdata_o,
    input  logic           dbus_gnt_i,
    input  logic           dbus_rvalid_i,
    input  logic [DW-1:0]  dbus_rdata_i
);

    lsu_state_e  state;
    logic        cap_is_load;
    logic [2:0]  cap_func3;
    logic [1:0]  cap_off;

    logic        is_ld;
    logic        is_st;
    logic        mem_op;
    logic        misalign;
    logic        access;
    logic [1:0]  off_m;
    logic [DW-1:0] ld_ext;

    assign is_ld  = (opcode_m == OPC_LOAD);
    assign is_st  = (opcode_m == OPC_STORE);
    assign mem_op = is_ld | is_st;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (func3_m)
            F3_H, F3_HU: misalign = alu_out_m[0];
            F3_W:        misalign = |alu_out_m[1:0];
            default:     misalign = 1'b0;
        endcase
    end
    assign misalign_o = mem_op & misalign;
`else
    assign misalign   = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign access = mem_op & ~misalign;
    assign off_m  = eff_off(func3_m, alu_out_m[1:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cap_is_load <= 1'b0;
            cap_func3   <= 3'b000;
            cap_off     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        cap_is_load <= is_ld;
                        cap_func3   <= func3_m;
                        cap_off     <= off_m;
                        state       <= dbus_gnt_i ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (dbus_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst_i drops the request asynchronously when reset hits
    // mid-access, before the state register has been observed as IDLE.
    assign dbus_req_o  = access & (state != RESP) & ~rst_i;
    assign stall_o     = access & ~((state == RESP) & dbus_rvalid_i);
    assign dbus_we_o   = is_st;
    assign dbus_addr_o = {alu_out_m[DW-1:2], 2'b00};

    lsu_align u_align (
        .is_load  (is_ld),
        .st_func3 (func3_m),
        .st_off   (off_m),
        .st_data  (write_data_m),
        .st_be    (dbus_be_o),
        .st_wdata (dbus_wdata_o),
        .ld_func3 (cap_func3),
        .ld_off   (cap_off),
        .ld_rdata (dbus_rdata_i),
        .ld_data  (ld_ext)
    );

    assign load_valid_o = (state == RESP) & dbus_rvalid_i & cap_is_load;
    assign load_data_o  = load_valid_o ? ld_ext : '0;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [6:0]  opcode_m;
    logic [2:0]  func3_m;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;

    int errors = 0;
    int checks = 0;

    lsu_mem_stage #(.DW(32), .BEW(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .opcode_m     (opcode_m),
        .func3_m      (func3_m),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .misalign_o   (misalign_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_be_o    (dbus_be_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_gnt_i   (dbus_gnt_i),
        .dbus_rvalid_i(dbus_rvalid_i),
        .dbus_rdata_i (dbus_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Drives one access from posedge+1, grant after gdly cycles, rvalid rdly
    // cycles after grant; returns what was observed.  Ends at posedge+1 of
    // the cycle after rvalid with the opcode removed.
    task automatic run_access(
        input  logic [6:0]  opc,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] rd,
        input  int          gdly,
        input  int          rdly,
        output int          n_stall,
        output int          n_req,
        output int          n_lv,
        output logic [31:0] ld,
        output logic [3:0]  be,
        output logic        we,
        output logic [31:0] wdo,
        output logic [31:0] ao,
        output logic        done
    );
        int  cnt;
        bit  granted;
        n_stall = 0; n_req = 0; n_lv = 0;
        ld = '0; be = '0; we = 1'b0; wdo = '0; ao = '0;
        done = 1'b0; granted = 1'b0; cnt = 0;
        opcode_m = opc; func3_m = f3; alu_out_m = addr; write_data_m = wd;
        for (int c = 0; c < 64 && !done; c++) begin
            dbus_gnt_i    = !granted && (cnt == gdly);
            dbus_rvalid_i = granted && (cnt == rdly);
            dbus_rdata_i  = dbus_rvalid_i ? rd : 32'h0;
            #2;
            if (stall_o) n_stall++;
            if (dbus_req_o) begin
                n_req++;
                be = dbus_be_o; we = dbus_we_o; wdo = dbus_wdata_o; ao = dbus_addr_o;
            end
            if (load_valid_o) begin
                n_lv++;
                ld = load_data_o;
            end
            if (dbus_rvalid_i) done = 1'b1;
            if (dbus_gnt_i) begin
                granted = 1'b1;
                cnt = 1;
            end else begin
                cnt++;
            end
            @(posedge clk_i); #1;
        end
        opcode_m = 7'h00; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        alu_out_m = 32'h0; write_data_m = 32'h0; opcode_m = 7'h00; func3_m = 3'b000;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
        #3;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
        checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", dbus_req_o); end
        checks++; if (load_valid_o !== 1'b0) begin errors++; $display("FAIL rst_lv: got %b expected 0", load_valid_o); end
        checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL rst_ld: got %h expected 0", load_data_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", misalign_o); end
        opcode_m = OPC_STORE; func3_m = 3'b010; alu_out_m = 32'h100;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rst_store_stall: got %b expected 1", stall_o); end
        checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL rst_store_req: got %b expected 0", dbus_req_o); end
        opcode_m = 7'h00;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_store_lanes;
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        run_access(OPC_STORE, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL sw_done: got %b expected 1", dn); end
        checks++; if (be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", be); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", we); end
        checks++; if (wdo !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", wdo); end
        checks++; if (ao !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 00000100", ao); end
        checks++; if (ns !== 1) begin errors++; $display("FAIL sw_stall_cycles: got %0d expected 1", ns); end
        checks++; if (nr !== 1) begin errors++; $display("FAIL sw_req_cycles: got %0d expected 1", nr); end
        checks++; if (nl !== 0) begin errors++; $display("FAIL sw_no_lv: got %0d expected 0", nl); end

        run_access(OPC_STORE, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (wdo !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", wdo); end
        checks++; if (be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", be); end
        checks++; if (ao !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", ao); end

        run_access(OPC_STORE, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (wdo !== 32'h12341234) begin errors++; $display("FAIL sh_wdata: got %h expected 12341234", wdo); end
        checks++; if (be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", be); end
    endtask

    task automatic test_load_extend;
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        run_access(OPC_LOAD, 3'b000, 32'h102, 32'h0, 32'h12F40000, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'hFFFFFFF4) begin errors++; $display("FAIL lb_data: got %h expected fffffff4", ld); end
        checks++; if (nl !== 1) begin errors++; $display("FAIL lb_lv: got %0d expected 1", nl); end
        checks++; if (be !== 4'b1111) begin errors++; $display("FAIL lb_be: got %b expected 1111", be); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b expected 0", we); end
        run_access(OPC_LOAD, 3'b100, 32'h102, 32'h0, 32'h12F40000, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'h000000F4) begin errors++; $display("FAIL lbu_data: got %h expected 000000f4", ld); end
        run_access(OPC_LOAD, 3'b001, 32'h102, 32'h0, 32'h80010000, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", ld); end
        run_access(OPC_LOAD, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'h00008001) begin errors++; $display("FAIL lhu_data: got %h expected 00008001", ld); end
        run_access(OPC_LOAD, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'h0000007F) begin errors++; $display("FAIL lb_pos_data: got %h expected 0000007f", ld); end
    endtask

    task automatic test_delays;
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        run_access(OPC_LOAD, 3'b001, 32'h200, 32'h0, 32'h0000ABCD, 2, 3, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL dly_done: got %b expected 1", dn); end
        checks++; if (ns !== 5) begin errors++; $display("FAIL dly_stall_cycles: got %0d expected 5", ns); end
        checks++; if (nr !== 3) begin errors++; $display("FAIL dly_req_cycles: got %0d expected 3", nr); end
        checks++; if (nl !== 1) begin errors++; $display("FAIL dly_lv_pulses: got %0d expected 1", nl); end
        checks++; if (ld !== 32'hFFFFABCD) begin errors++; $display("FAIL dly_data: got %h expected ffffabcd", ld); end
    endtask

    task automatic test_back_to_back;
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        run_access(OPC_LOAD, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_lw_data: got %h expected cafef00d", ld); end
        run_access(OPC_STORE, 3'b010, 32'h304, 32'h01020304, 32'h0, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ns !== 1) begin errors++; $display("FAIL b2b_sw_stall: got %0d expected 1", ns); end
        checks++; if (nr !== 1) begin errors++; $display("FAIL b2b_sw_req: got %0d expected 1", nr); end
        run_access(OPC_LOAD, 3'b010, 32'h308, 32'h0, 32'h0BADBEEF, 0, 2, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ns !== 2) begin errors++; $display("FAIL b2b_lw2_stall: got %0d expected 2", ns); end
        checks++; if (ld !== 32'h0BADBEEF) begin errors++; $display("FAIL b2b_lw2_data: got %h expected 0badbeef", ld); end
    endtask

    task automatic test_spurious;
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        opcode_m = 7'h13; dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFFFFFF;
        #2;
        checks++; if (load_valid_o !== 1'b0) begin errors++; $display("FAIL spur_lv: got %b expected 0", load_valid_o); end
        checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL spur_ld: got %h expected 0", load_data_o); end
        checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL spur_req: got %b expected 0", dbus_req_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL spur_stall: got %b expected 0", stall_o); end
        @(posedge clk_i); #1;
        opcode_m = 7'h00; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
        run_access(OPC_STORE, 3'b010, 32'h40, 32'h1, 32'h0, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ns !== 1) begin errors++; $display("FAIL spur_after_stall: got %0d expected 1", ns); end
    endtask

    task automatic test_reset_mid;
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        opcode_m = OPC_LOAD; func3_m = 3'b010; alu_out_m = 32'h100; dbus_gnt_i = 1'b1;
        #2;
        checks++; if (dbus_req_o !== 1'b1) begin errors++; $display("FAIL rmid_req0: got %b expected 1", dbus_req_o); end
        @(posedge clk_i); #1;
        dbus_gnt_i = 1'b0;
        #1;
        rst_i = 1'b1;
        #1;
        checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req_rst: got %b expected 0", dbus_req_o); end
        checks++; if (load_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_lv_rst: got %b expected 0", load_valid_o); end
        opcode_m = 7'h00;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFFFFFF;
        #2;
        checks++; if (load_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_late_lv: got %b expected 0", load_valid_o); end
        checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL rmid_late_ld: got %h expected 0", load_data_o); end
        checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL rmid_late_req: got %b expected 0", dbus_req_o); end
        @(posedge clk_i); #1;
        dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
        run_access(OPC_LOAD, 3'b010, 32'h104, 32'h0, 32'h00000005, 1, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (nr !== 2) begin errors++; $display("FAIL rmid_idle_req: got %0d expected 2", nr); end
        checks++; if (ns !== 2) begin errors++; $display("FAIL rmid_idle_stall: got %0d expected 2", ns); end
        checks++; if (ld !== 32'h5) begin errors++; $display("FAIL rmid_idle_data: got %h expected 00000005", ld); end
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
        opcode_m = OPC_LOAD; func3_m = 3'b010; alu_out_m = 32'h102;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", misalign_o); end
            checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", dbus_req_o); end
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b expected 0", stall_o); end
            checks++; if (load_valid_o !== 1'b0) begin errors++; $display("FAIL mis_lv: got %b expected 0", load_valid_o); end
            @(posedge clk_i); #1;
        end
        opcode_m = OPC_STORE; func3_m = 3'b001; alu_out_m = 32'h203;
        #2;
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL mis_sh_flag: got %b expected 1", misalign_o); end
        checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL mis_sh_req: got %b expected 0", dbus_req_o); end
        @(posedge clk_i); #1;
        opcode_m = 7'h00;
`else
        int ns, nr, nl; logic [31:0] ld, wdo, ao; logic [3:0] be; logic we, dn;
        opcode_m = OPC_LOAD; func3_m = 3'b010; alu_out_m = 32'h102;
        #1;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_tied: got %b expected 0", misalign_o); end
        opcode_m = 7'h00;
        @(posedge clk_i); #1;
        run_access(OPC_LOAD, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ao !== 32'h100) begin errors++; $display("FAIL mis_lw_addr: got %h expected 00000100", ao); end
        checks++; if (ld !== 32'h11223344) begin errors++; $display("FAIL mis_lw_data: got %h expected 11223344", ld); end
        checks++; if (nr !== 1) begin errors++; $display("FAIL mis_lw_req: got %0d expected 1", nr); end
        run_access(OPC_LOAD, 3'b001, 32'h103, 32'h0, 32'h80010000, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (ld !== 32'hFFFF8001) begin errors++; $display("FAIL mis_lh_data: got %h expected ffff8001", ld); end
        run_access(OPC_STORE, 3'b001, 32'h101, 32'h0000BEEF, 32'h0, 0, 1, ns, nr, nl, ld, be, we, wdo, ao, dn);
        checks++; if (be !== 4'b0011) begin errors++; $display("FAIL mis_sh_be: got %b expected 0011", be); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_lanes();
        test_load_extend();
        test_delays();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
